// File: rtl/sipo_deser_hs.sv
// sipo_deser_hs: serial-to-parallel deserializer. A frame starts on a programmed cycle-counter
// slot or an external start pulse, and each finished word is held in a valid/ready output register.
module sipo_deser_hs #(
  parameter int WIDTH       = 128,
  parameter int CNT_W       = 16,
  parameter int PERIOD      = 1024,
  parameter int START_CYCLE = 289,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     shift_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     out_ready,
  input  logic                     clr_overrun,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun
);

  localparam int                BC_W      = $clog2(WIDTH);
  localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(START_CYCLE);

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_data;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_overrun;
  logic [BC_W-1:0]    r_bit_count;

  logic               w_trigger;
  logic               w_last;
  logic               w_xfer;
  logic               w_accept;
  logic [BC_W-1:0]    w_pos;
  logic [WIDTH-1:0]   w_word;

  assign w_trigger = start | (r_cycle_count == CNT_START);
  assign w_last    = shift_en & (r_bit_count == LAST_BIT);
  assign w_xfer    = r_out_valid & out_ready;
  // A completed word may load if the register is empty or its old word leaves this same edge.
  assign w_accept  = ~r_out_valid | out_ready;
  assign w_pos     = MSB_FIRST ? (LAST_BIT - r_bit_count) : r_bit_count;

  always_comb begin
    w_word        = r_shift;
    w_word[w_pos] = serial_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cycle_count <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_bit_count   <= '0;
    end else begin
      r_cycle_count <= (r_cycle_count == CNT_LAST) ? '0 : r_cycle_count + 1'b1;
      if (w_xfer)      r_out_valid <= 1'b0;
      // Later set of overrun in the completion branch overrides this clear.
      if (clr_overrun) r_overrun   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state     <= S_CAPTURE;
            r_busy      <= 1'b1;
            r_bit_count <= '0;
            r_shift     <= '0;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_bit_count <= '0;
            r_shift     <= '0;
          end else if (w_last) begin
            r_bit_count <= '0;
            r_shift     <= '0;
            if (w_accept) begin
              r_data      <= w_word;
              r_out_valid <= 1'b1;
            end else begin
              r_overrun   <= 1'b1;
            end
            if (!CONTINUOUS) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (shift_en) begin
            r_shift     <= w_word;
            r_bit_count <= r_bit_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bit_count = r_bit_count;
  assign overrun   = r_overrun;

endmodule
